// File: rtl/fp_pkg.sv
// Shared types and helpers for the FP normalise/round back end.
package fp_pkg;

    localparam int unsigned DefEWidth = 8;
    localparam int unsigned DefMWidth = 23;

    typedef enum logic [2:0] {
        RmRne = 3'd0,
        RmRtz = 3'd1,
        RmRdn = 3'd2,
        RmRup = 3'd3,
        RmRmm = 3'd4
    } rmode_e;

    typedef struct packed {
        logic g;
        logic r;
        logic s;
    } grs_t;

    function automatic int unsigned bias_of(input int unsigned e_width);
        return (32'd1 << (e_width - 1)) - 32'd1;
    endfunction

    // Canonical quiet NaN in the low e_width+m_width+1 bits: exp all ones, frac MSB set.
    function automatic logic [63:0] qnan_bits(input int unsigned e_width,
                                              input int unsigned m_width);
        logic [63:0] v;
        v = ((64'd1 << e_width) - 64'd1) << m_width;
        v = v | (64'd1 << (m_width - 1));
        return v;
    endfunction

endpackage

// File: rtl/fp_round_inc.sv
// Combinational rounding increment for an M_WIDTH+1-bit significand with GRS bits.
module fp_round_inc
    import fp_pkg::*;
#(
    parameter int unsigned M_WIDTH = DefMWidth
) (
    input  logic [M_WIDTH:0] sig,
    input  grs_t             grs,
    input  logic             sign,
    input  rmode_e           mode,
    output logic [M_WIDTH:0] rounded,
    output logic             carry,
    output logic             inexact
);

    logic inc;

    always_comb begin
        inexact = grs.g | grs.r | grs.s;
        case (mode)
            RmRtz:   inc = 1'b0;
            RmRdn:   inc = sign & inexact;
            RmRup:   inc = !sign & inexact;
            RmRmm:   inc = grs.g;
            // Unused codes fall back to round-to-nearest-even.
            default: inc = grs.g & (grs.r | grs.s | sig[0]);
        endcase
        {carry, rounded} = {1'b0, sig} + (M_WIDTH + 2)'(inc);
    end

endmodule

// File: rtl/fp_norm_round_pipe.sv
// Two-stage normalise / round / pack back end for the FP multiplier.
// Optional FP_RMODE_EN adds a per-beat rounding-mode input (default build: RNE only).
module fp_norm_round_pipe
    import fp_pkg::*;
#(
    parameter int unsigned E_WIDTH = DefEWidth,
    parameter int unsigned M_WIDTH = DefMWidth,
    parameter int unsigned BIAS    = 127
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_sign,
    input  logic [E_WIDTH+1:0]         in_exp,
    input  logic [M_WIDTH+1:0]         in_man,
    input  logic [2:0]                 in_grs,
    input  logic                       in_nan,
    input  logic                       in_inf,
    input  logic                       in_zero,
`ifdef FP_RMODE_EN
    input  logic [2:0]                 rmode,
`endif
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [E_WIDTH+M_WIDTH:0]   res,
    output logic                       flag_ovf,
    output logic                       flag_unf,
    output logic                       flag_inx
);

    localparam int unsigned XW = E_WIDTH + 3;
    localparam int unsigned RW = E_WIDTH + M_WIDTH + 1;

    localparam logic signed [XW-1:0]  BiasX     = XW'(BIAS);
    localparam logic signed [XW-1:0]  ExpMax    = XW'((1 << E_WIDTH) - 1);
    localparam logic signed [XW-1:0]  ExpZero   = '0;
    localparam logic [E_WIDTH-1:0]    ExpOnes   = '1;
    localparam logic [E_WIDTH-1:0]    ExpMaxFin = {{(E_WIDTH - 1){1'b1}}, 1'b0};
    localparam logic [63:0]           QNanFull  = qnan_bits(E_WIDTH, M_WIDTH);
    localparam logic [RW-1:0]         QNan      = QNanFull[RW-1:0];

    rmode_e in_mode;
`ifdef FP_RMODE_EN
    assign in_mode = rmode_e'(rmode);
`else
    assign in_mode = RmRne;
`endif

    // Stage 1: normalise
    logic                   shift;
    logic [M_WIDTH:0]       n_sig;
    grs_t                   in_grs_s;
    grs_t                   n_grs;
    logic signed [XW-1:0]   n_exp;

    assign shift    = in_man[M_WIDTH+1];
    assign in_grs_s = grs_t'(in_grs);

    always_comb begin
        n_sig = in_man[M_WIDTH:0];
        n_grs = in_grs_s;
        if (shift) begin
            n_sig   = in_man[M_WIDTH+1:1];
            n_grs.g = in_man[0];
            n_grs.r = in_grs_s.g;
            n_grs.s = in_grs_s.r | in_grs_s.s;
        end
        n_exp = signed'(XW'(in_exp)) - BiasX + signed'(XW'(shift));
    end

    logic                   s1_valid;
    logic                   s1_sign;
    logic [M_WIDTH:0]       s1_sig;
    grs_t                   s1_grs;
    logic signed [XW-1:0]   s1_exp;
    logic                   s1_nan;
    logic                   s1_inf;
    logic                   s1_zero;
    rmode_e                 s1_mode;
    logic                   s2_load;

    assign s2_load  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_load;

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
        end
        if (in_valid && in_ready) begin
            s1_sign <= in_sign;
            s1_sig  <= n_sig;
            s1_grs  <= n_grs;
            s1_exp  <= n_exp;
            s1_nan  <= in_nan;
            s1_inf  <= in_inf;
            s1_zero <= in_zero;
            s1_mode <= in_mode;
        end
    end

    // Stage 2: round, range check, pack
    logic [M_WIDTH:0]       rnd_sig;
    logic                   rnd_carry;
    logic                   rnd_inx;
    logic signed [XW-1:0]   exp_r;
    logic                   sat;
    logic [RW-1:0]          res_d;
    logic                   ovf_d;
    logic                   unf_d;
    logic                   inx_d;
    logic                   unused_hidden;

    fp_round_inc #(
        .M_WIDTH (M_WIDTH)
    ) u_round (
        .sig     (s1_sig),
        .grs     (s1_grs),
        .sign    (s1_sign),
        .mode    (s1_mode),
        .rounded (rnd_sig),
        .carry   (rnd_carry),
        .inexact (rnd_inx)
    );

    // On carry-out the fraction bits are already zero, so only the exponent moves.
    assign exp_r         = s1_exp + signed'(XW'(rnd_carry));
    assign unused_hidden = rnd_sig[M_WIDTH];

`ifdef FP_RMODE_EN
    assign sat = (s1_mode == RmRtz) || (s1_mode == RmRdn && !s1_sign) ||
                 (s1_mode == RmRup && s1_sign);
`else
    assign sat = 1'b0;
`endif

    always_comb begin
        res_d = {s1_sign, exp_r[E_WIDTH-1:0], rnd_sig[M_WIDTH-1:0]};
        ovf_d = 1'b0;
        unf_d = 1'b0;
        inx_d = rnd_inx;
        if (s1_nan) begin
            res_d = QNan;
            inx_d = 1'b0;
        end else if (s1_inf) begin
            res_d = {s1_sign, ExpOnes, {M_WIDTH{1'b0}}};
            inx_d = 1'b0;
        end else if (s1_zero) begin
            res_d = {s1_sign, {(RW - 1){1'b0}}};
            inx_d = 1'b0;
        end else if (exp_r >= ExpMax) begin
            res_d = sat ? {s1_sign, ExpMaxFin, {M_WIDTH{1'b1}}}
                        : {s1_sign, ExpOnes, {M_WIDTH{1'b0}}};
            ovf_d = 1'b1;
            inx_d = 1'b1;
        end else if (exp_r <= ExpZero) begin
            res_d = {s1_sign, {(RW - 1){1'b0}}};
            unf_d = 1'b1;
            inx_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid <= 1'b0;
            res       <= '0;
            flag_ovf  <= 1'b0;
            flag_unf  <= 1'b0;
            flag_inx  <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                res      <= res_d;
                flag_ovf <= ovf_d;
                flag_unf <= unf_d;
                flag_inx <= inx_d;
            end
        end
    end

endmodule

// File: tb/tb_fp_norm_round_pipe.sv
// Directed table-driven bench for fp_norm_round_pipe (single precision).
module tb_fp_norm_round_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [24:0] in_man;
    logic [2:0]  in_grs;
    logic        in_nan;
    logic        in_inf;
    logic        in_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] res;
    logic        flag_ovf;
    logic        flag_unf;
    logic        flag_inx;
`ifdef FP_RMODE_EN
    logic [2:0]  rmode = 3'd0;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fp_norm_round_pipe #(
        .E_WIDTH (8),
        .M_WIDTH (23),
        .BIAS    (127)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_man    (in_man),
        .in_grs    (in_grs),
        .in_nan    (in_nan),
        .in_inf    (in_inf),
        .in_zero   (in_zero),
`ifdef FP_RMODE_EN
        .rmode     (rmode),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .flag_ovf  (flag_ovf),
        .flag_unf  (flag_unf),
        .flag_inx  (flag_inx)
    );

    typedef struct {
        logic        sign;
        logic [9:0]  exp;
        logic [24:0] man;
        logic [2:0]  grs;
        logic [2:0]  sp;   // {nan, inf, zero}
        logic [31:0] res;
        logic [2:0]  flg;  // {ovf, unf, inx}
    } vec_t;

    localparam int NV = 16;
    vec_t vt[NV];
    int   sq[$];

    function automatic vec_t mk(input logic s, input int e, input logic [24:0] m,
                                input logic [2:0] g, input logic [2:0] sp,
                                input logic [31:0] r, input logic [2:0] f);
        vec_t v;
        v.sign = s;
        v.exp  = 10'(e);
        v.man  = m;
        v.grs  = g;
        v.sp   = sp;
        v.res  = r;
        v.flg  = f;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input int i);
        in_sign = vt[i].sign;
        in_exp  = vt[i].exp;
        in_man  = vt[i].man;
        in_grs  = vt[i].grs;
        in_nan  = vt[i].sp[2];
        in_inf  = vt[i].sp[1];
        in_zero = vt[i].sp[0];
    endtask

    task automatic single(input int i);
        int n;
        int lat;
        @(negedge clk);
        out_ready = 1'b1;
        drive(i);
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        check($sformatf("v%0d_lat", i), 32'(lat), 32'd2);
        check($sformatf("v%0d_res", i), res, vt[i].res);
        check($sformatf("v%0d_flg", i), {29'd0, flag_ovf, flag_unf, flag_inx},
              {29'd0, vt[i].flg});
    endtask

    // Streams the beats listed in sq; out_ready is held low for the first `hold` cycles.
    task automatic stream(input int hold, input int max_cyc, output int cycles,
                          output int sent_at_hold, output logic ready_at_hold);
        int   sent;
        int   got;
        logic fire;
        sent = 0;
        got = 0;
        cycles = 0;
        sent_at_hold = 0;
        ready_at_hold = 1'b1;
        for (int cyc = 0; cyc < max_cyc && got < sq.size(); cyc++) begin
            @(negedge clk);
            cycles = cyc + 1;
            out_ready = (cyc >= hold);
            if (sent < sq.size()) begin
                drive(sq[sent]);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            if (cyc == hold - 1) begin
                sent_at_hold = sent;
                ready_at_hold = in_ready;
            end
            if (out_valid && got < sq.size()) begin
                check($sformatf("strm%0d_res", got), res, vt[sq[got]].res);
                check($sformatf("strm%0d_flg", got), {29'd0, flag_ovf, flag_unf, flag_inx},
                      {29'd0, vt[sq[got]].flg});
                if (out_ready) got++;
            end
            fire = in_valid && in_ready;
            @(posedge clk);
            if (fire) sent++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("strm_count", 32'(got), 32'(sq.size()));
    endtask

    initial begin
        int   cycles;
        int   sent_h;
        logic rdy_h;

        vt[0]  = mk(0, 254, {2'b10, 23'h200000}, 3'b000, 3'b000, 32'h40100000, 3'b000);
        vt[1]  = mk(0, 254, {2'b01, 23'h000001}, 3'b100, 3'b000, 32'h3F800002, 3'b001);
        vt[2]  = mk(0, 254, {2'b01, 23'h000002}, 3'b100, 3'b000, 32'h3F800002, 3'b001);
        vt[3]  = mk(0, 254, {2'b01, 23'h7FFFFF}, 3'b110, 3'b000, 32'h40000000, 3'b001);
        vt[4]  = mk(1, 382, {2'b01, 23'h000000}, 3'b000, 3'b000, 32'hFF800000, 3'b101);
        vt[5]  = mk(0, 100, {2'b01, 23'h000000}, 3'b000, 3'b000, 32'h00000000, 3'b011);
        vt[6]  = mk(0, 254, {2'b01, 23'h000000}, 3'b000, 3'b110, 32'h7FC00000, 3'b000);
        vt[7]  = mk(1, 254, {2'b01, 23'h000000}, 3'b000, 3'b001, 32'h80000000, 3'b000);
        vt[8]  = mk(0, 381, {2'b01, 23'h7FFFFF}, 3'b100, 3'b000, 32'h7F800000, 3'b101);
        vt[9]  = mk(0, 128, {2'b01, 23'h000000}, 3'b000, 3'b000, 32'h00800000, 3'b000);
        vt[10] = mk(0, 127, {2'b01, 23'h000000}, 3'b000, 3'b000, 32'h00000000, 3'b011);
        vt[11] = mk(0, 254, {2'b10, 23'h000001}, 3'b100, 3'b000, 32'h40000001, 3'b001);
        vt[12] = mk(1, 254, {2'b01, 23'h000001}, 3'b011, 3'b000, 32'hBF800001, 3'b001);
        vt[13] = mk(1, 300, {2'b11, 23'h000000}, 3'b000, 3'b000, 32'hD7400000, 3'b000);
        vt[14] = mk(1, 5,   {2'b01, 23'h000000}, 3'b111, 3'b011, 32'hFF800000, 3'b000);
        vt[15] = mk(0, 381, {2'b01, 23'h000000}, 3'b000, 3'b000, 32'h7F000000, 3'b000);

        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        drive(0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ovalid", {31'd0, out_valid}, 32'd0);
        check("rst_res", res, 32'd0);
        check("rst_flg", {29'd0, flag_ovf, flag_unf, flag_inx}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_iready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < NV; i++) single(i);

        // Full throughput: one result per cycle after a 2-cycle fill.
        sq.delete();
        for (int i = 0; i < NV; i++) sq.push_back(i);
        stream(0, 100, cycles, sent_h, rdy_h);
        check("thru_cycles", 32'(cycles), 32'(NV + 2));

        // Backpressure: 5 stalled cycles, 3 beats offered.
        sq.delete();
        sq.push_back(0);
        sq.push_back(3);
        sq.push_back(11);
        stream(5, 40, cycles, sent_h, rdy_h);
        check("bp_accepted", 32'(sent_h), 32'd2);
        check("bp_iready", {31'd0, rdy_h}, 32'd0);

        // Reset mid-stream drops in-flight beats.
        @(negedge clk);
        out_ready = 1'b1;
        drive(1);
        in_valid = 1'b1;
        @(negedge clk);
        drive(3);
        @(negedge clk);
        check("mid_pre_ovalid", {31'd0, out_valid}, 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check("mid_ovalid", {31'd0, out_valid}, 32'd0);
        check("mid_res", res, 32'd0);
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("mid_iready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        check("mid_no_ghost", {31'd0, out_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
